// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: processor port A and external/debug port B share one RAM.
// Round-robin with a bounded bus lock for B; one grant per cycle, reads return two cycles later.
module dm_arbiter #(
    parameter int unsigned MSB_ADDR = 11,
    parameter int unsigned MSB_DATA = 11,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic                CLOCK_i,
    input  logic                RESET_i,

    input  logic                REQ_A_i,
    input  logic                WE_A_i,
    input  logic [MSB_ADDR-1:0] ADDR_A_i,
    input  logic [MSB_DATA-1:0] WDATA_A_i,
    output logic                GNT_A_o,
    output logic                RVALID_A_o,
    output logic [MSB_DATA-1:0] RDATA_A_o,
    output logic                HOLD_A_o,

    input  logic                REQ_B_i,
    input  logic                WE_B_i,
    input  logic                LOCK_B_i,
    input  logic [MSB_ADDR-1:0] ADDR_B_i,
    input  logic [MSB_DATA-1:0] WDATA_B_i,
    output logic                GNT_B_o,
    output logic                RVALID_B_o,
    output logic [MSB_DATA-1:0] RDATA_B_o,

    output logic                WRRAM_o,
    output logic [MSB_ADDR-1:0] ADDR_dm_o,
    output logic [MSB_DATA-1:0] IN_DATA_o,
    input  logic [MSB_DATA-1:0] OUT_DATA_i
);

    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(LOCK_MAX);

    typedef enum logic {StOpen, StLocked} state_e;

    state_e              state_q, state_d;
    logic                last_b_q, last_b_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic                wr_q, wr_d;
    logic [MSB_ADDR-1:0] addr_q, addr_d;
    logic [MSB_DATA-1:0] wdata_q, wdata_d;
    logic                rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic                rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
    logic [MSB_DATA-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;

    logic release_now, lock_active, force_a;
    logic gnt_a, gnt_b;

    // Release is combinational so a waiting A can be granted in the very cycle B lets go.
    always_comb begin
        release_now = (state_q == StLocked) && !REQ_B_i && !LOCK_B_i;
        lock_active = (state_q == StLocked) && !release_now;
        force_a     = lock_active && REQ_A_i && (cnt_q == CntMax);
        gnt_a       = 1'b0;
        gnt_b       = 1'b0;
        if (RESET_i) begin
            if (lock_active) begin
                gnt_a = force_a;
                gnt_b = !force_a && REQ_B_i;
            end else if (REQ_A_i && REQ_B_i) begin
                gnt_a = last_b_q;
                gnt_b = !last_b_q;
            end else begin
                gnt_a = REQ_A_i;
                gnt_b = REQ_B_i;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        cnt_d    = cnt_q;
        if (gnt_b) begin
            last_b_d = 1'b1;
            if (LOCK_B_i) begin
                state_d = StLocked;
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end else begin
                state_d = StOpen;
                cnt_d   = '0;
            end
        end else if (gnt_a) begin
            last_b_d = 1'b0;
            cnt_d    = '0;
            // A forced grant keeps the lock; B resumes its burst afterwards.
            state_d  = lock_active ? StLocked : StOpen;
        end else if (release_now) begin
            state_d = StOpen;
            cnt_d   = '0;
        end
    end

    always_comb begin
        wr_d    = (gnt_a && WE_A_i) || (gnt_b && WE_B_i);
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (gnt_a) begin
            addr_d  = ADDR_A_i;
            wdata_d = WDATA_A_i;
        end else if (gnt_b) begin
            addr_d  = ADDR_B_i;
            wdata_d = WDATA_B_i;
        end
        rd_a_d     = gnt_a && !WE_A_i;
        rd_b_d     = gnt_b && !WE_B_i;
        // RAM read data belongs to the command shown this cycle.
        rvalid_a_d = rd_a_q;
        rvalid_b_d = rd_b_q;
        rdata_a_d  = rd_a_q ? OUT_DATA_i : rdata_a_q;
        rdata_b_d  = rd_b_q ? OUT_DATA_i : rdata_b_q;
    end

    always_ff @(posedge CLOCK_i or negedge RESET_i) begin
        if (!RESET_i) begin
            state_q    <= StOpen;
            last_b_q   <= 1'b1;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_a_q     <= 1'b0;
            rd_b_q     <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
        end
    end

    assign GNT_A_o    = gnt_a;
    assign GNT_B_o    = gnt_b;
    assign HOLD_A_o   = REQ_A_i && !gnt_a;
    assign WRRAM_o    = wr_q;
    assign ADDR_dm_o  = addr_q;
    assign IN_DATA_o  = wdata_q;
    assign RVALID_A_o = rvalid_a_q;
    assign RVALID_B_o = rvalid_b_q;
    assign RDATA_A_o  = rdata_a_q;
    assign RDATA_B_o  = rdata_b_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random traffic against a transaction-level model
// that tracks lock/round-robin policy, a shadow memory and a queue of due read returns.
module tb_dm_arbiter;

    localparam int AW   = 11;
    localparam int DW   = 11;
    localparam int LM   = 16;
    localparam int RamN = 1 << AW;

    logic          CLOCK_i = 1'b0;
    logic          RESET_i;
    logic          REQ_A_i, WE_A_i, REQ_B_i, WE_B_i, LOCK_B_i;
    logic [AW-1:0] ADDR_A_i, ADDR_B_i, ADDR_dm_o;
    logic [DW-1:0] WDATA_A_i, WDATA_B_i, IN_DATA_o, OUT_DATA_i;
    logic [DW-1:0] RDATA_A_o, RDATA_B_o;
    logic          GNT_A_o, GNT_B_o, RVALID_A_o, RVALID_B_o, HOLD_A_o, WRRAM_o;

    dm_arbiter #(.MSB_ADDR(AW), .MSB_DATA(DW), .LOCK_MAX(LM)) dut (
        .CLOCK_i   (CLOCK_i),
        .RESET_i   (RESET_i),
        .REQ_A_i   (REQ_A_i),
        .WE_A_i    (WE_A_i),
        .ADDR_A_i  (ADDR_A_i),
        .WDATA_A_i (WDATA_A_i),
        .GNT_A_o   (GNT_A_o),
        .RVALID_A_o(RVALID_A_o),
        .RDATA_A_o (RDATA_A_o),
        .HOLD_A_o  (HOLD_A_o),
        .REQ_B_i   (REQ_B_i),
        .WE_B_i    (WE_B_i),
        .LOCK_B_i  (LOCK_B_i),
        .ADDR_B_i  (ADDR_B_i),
        .WDATA_B_i (WDATA_B_i),
        .GNT_B_o   (GNT_B_o),
        .RVALID_B_o(RVALID_B_o),
        .RDATA_B_o (RDATA_B_o),
        .WRRAM_o   (WRRAM_o),
        .ADDR_dm_o (ADDR_dm_o),
        .IN_DATA_o (IN_DATA_o),
        .OUT_DATA_i(OUT_DATA_i)
    );

    always #5 CLOCK_i = ~CLOCK_i;

    // RAM with asynchronous read; cleared on the first clock edge.
    logic [DW-1:0] ram [RamN];
    logic          ram_ready = 1'b0;
    assign OUT_DATA_i = ram[ADDR_dm_o];
    always @(posedge CLOCK_i) begin
        if (!ram_ready) begin
            for (int i = 0; i < RamN; i++) ram[i] <= '0;
            ram_ready <= 1'b1;
        end else if (WRRAM_o) begin
            ram[ADDR_dm_o] <= IN_DATA_o;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model state
    typedef struct {
        logic          port_b;
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    rd_t           rq[$];
    logic [DW-1:0] ref_mem [RamN];
    logic          m_locked, m_last_b, m_wr;
    int            m_cnt, cyc;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata_a, m_rdata_b;

    logic          obs_ga, obs_gb, obs_hold, obs_wr, obs_rva, obs_rvb;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_wd, obs_rda;

    task automatic model_reset();
        m_locked  = 1'b0;
        m_last_b  = 1'b1;
        m_cnt     = 0;
        m_wr      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_rdata_a = '0;
        m_rdata_b = '0;
        rq.delete();
    endtask

    // One clock cycle: drive, check at the falling edge, then advance the model.
    task automatic step(input logic ra, input logic wa, input logic [AW-1:0] aa,
                        input logic [DW-1:0] da, input logic rb, input logic wb,
                        input logic lk, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        logic ega, egb, erva, ervb, released;
        REQ_A_i = ra; WE_A_i = wa; ADDR_A_i = aa; WDATA_A_i = da;
        REQ_B_i = rb; WE_B_i = wb; LOCK_B_i = lk; ADDR_B_i = ab; WDATA_B_i = db;
        @(negedge CLOCK_i);
        released = m_locked && !rb && !lk;
        ega = 1'b0;
        egb = 1'b0;
        if (m_locked && !released) begin
            if (ra && m_cnt >= LM) ega = 1'b1;
            else egb = rb;
        end else if (ra && rb) begin
            ega = m_last_b;
            egb = !m_last_b;
        end else begin
            ega = ra;
            egb = rb;
        end
        erva = 1'b0;
        ervb = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].port_b) begin ervb = 1'b1; m_rdata_b = rq[0].data; end
            else begin erva = 1'b1; m_rdata_a = rq[0].data; end
            void'(rq.pop_front());
        end
        obs_ga = GNT_A_o; obs_gb = GNT_B_o; obs_hold = HOLD_A_o; obs_wr = WRRAM_o;
        obs_addr = ADDR_dm_o; obs_wd = IN_DATA_o; obs_rva = RVALID_A_o; obs_rvb = RVALID_B_o;
        obs_rda = RDATA_A_o;
        check_eq("gnt_a", GNT_A_o, ega);
        check_eq("gnt_b", GNT_B_o, egb);
        check_eq("hold_a", HOLD_A_o, ra && !ega);
        check_eq("wrram", WRRAM_o, m_wr);
        check_eq("addr_dm", ADDR_dm_o, m_addr);
        check_eq("in_data", IN_DATA_o, m_wdata);
        check_eq("rvalid_a", RVALID_A_o, erva);
        check_eq("rvalid_b", RVALID_B_o, ervb);
        check_eq("rdata_a", RDATA_A_o, m_rdata_a);
        check_eq("rdata_b", RDATA_B_o, m_rdata_b);
        if (ega || egb) begin
            m_wr    = ega ? wa : wb;
            m_addr  = ega ? aa : ab;
            m_wdata = ega ? da : db;
            if (m_wr) ref_mem[m_addr] = m_wdata;
            else rq.push_back('{port_b: egb, data: ref_mem[m_addr], due: cyc + 2});
        end else begin
            m_wr = 1'b0;
        end
        if (egb) begin
            m_last_b = 1'b1;
            if (lk) begin
                m_locked = 1'b1;
                if (m_cnt < LM) m_cnt++;
            end else begin
                m_locked = 1'b0;
                m_cnt    = 0;
            end
        end else if (ega) begin
            m_last_b = 1'b0;
            m_cnt    = 0;
            m_locked = m_locked && !released;
        end else if (released) begin
            m_locked = 1'b0;
            m_cnt    = 0;
        end
        cyc++;
        @(posedge CLOCK_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    // Asserts reset from the current point in a cycle; requests are held high to show gating.
    task automatic do_reset();
        REQ_A_i = 1'b1;
        REQ_B_i = 1'b1;
        #1 RESET_i = 1'b0;
        #1;
        check_eq("rst_gnt_a", GNT_A_o, 0);
        check_eq("rst_gnt_b", GNT_B_o, 0);
        check_eq("rst_wrram", WRRAM_o, 0);
        check_eq("rst_addr", ADDR_dm_o, 0);
        check_eq("rst_in_data", IN_DATA_o, 0);
        check_eq("rst_rvalid_a", RVALID_A_o, 0);
        check_eq("rst_rvalid_b", RVALID_B_o, 0);
        check_eq("rst_rdata_a", RDATA_A_o, 0);
        check_eq("rst_rdata_b", RDATA_B_o, 0);
        @(posedge CLOCK_i);
        @(posedge CLOCK_i);
        @(negedge CLOCK_i);
        REQ_A_i = 1'b0;
        REQ_B_i = 1'b0;
        RESET_i = 1'b1;
        model_reset();
        @(posedge CLOCK_i);
        #1;
    endtask

    int b_before_a, b_after_a, a_grants, b_total, saw_rvb;

    initial begin
        RESET_i = 1'b0;
        REQ_A_i = 0; WE_A_i = 0; ADDR_A_i = '0; WDATA_A_i = '0;
        REQ_B_i = 0; WE_B_i = 0; LOCK_B_i = 0; ADDR_B_i = '0; WDATA_B_i = '0;
        cyc = 0;
        for (int i = 0; i < RamN; i++) ref_mem[i] = '0;
        model_reset();
        do_reset();

        // Single write then read-back on A
        step(1, 1, 11'h010, 11'h155, 0, 0, 0, '0, '0);
        check_eq("wr_gnt_a", obs_ga, 1);
        idle(1);
        check_eq("wr_cmd_we", obs_wr, 1);
        check_eq("wr_cmd_addr", obs_addr, 11'h010);
        check_eq("wr_cmd_data", obs_wd, 11'h155);
        step(1, 0, 11'h010, '0, 0, 0, 0, '0, '0);
        idle(1);
        check_eq("rd_t1_rvalid", obs_rva, 0);
        idle(1);
        check_eq("rd_t2_rvalid", obs_rva, 1);
        check_eq("rd_t2_rdata", obs_rda, 11'h155);
        idle(1);
        check_eq("rd_t3_rvalid", obs_rva, 0);

        // Continuous contention from reset alternates A,B,...
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, 0, AW'(i), '0, 1, 0, 0, 11'h010, '0);
            check_eq("alt_gnt_a", obs_ga, (i % 2) == 0);
            check_eq("alt_hold_a", obs_hold, (i % 2) == 1);
        end
        idle(3);

        // Locked B burst of 20 with A waiting: 16 B, forced A, 4 B
        do_reset();
        step(0, 0, '0, '0, 1, 1, 1, 11'h020, 11'h001);
        b_total = obs_gb ? 1 : 0;
        b_before_a = b_total;
        b_after_a = 0;
        a_grants = 0;
        for (int i = 0; i < 40 && b_total < 20; i++) begin
            step(1, 0, 11'h010, '0, 1, 1, 1, AW'(11'h020 + i), DW'(i));
            if (obs_ga) a_grants++;
            if (obs_gb) begin
                b_total++;
                if (a_grants == 0) b_before_a++;
                else b_after_a++;
            end
        end
        check_eq("lock_b_before_a", b_before_a, 16);
        check_eq("lock_a_grants", a_grants, 1);
        check_eq("lock_b_after_a", b_after_a, 4);
        step(1, 0, 11'h010, '0, 0, 0, 0, '0, '0);
        check_eq("lock_release_a", obs_ga, 1);
        idle(3);

        // Reset during an in-flight B read
        do_reset();
        step(0, 0, '0, '0, 1, 0, 0, 11'h010, '0);
        do_reset();
        saw_rvb = 0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            if (obs_rvb) saw_rvb++;
        end
        check_eq("rst_inflight_rvb", saw_rvb, 0);
        step(1, 0, 11'h011, '0, 1, 0, 1, 11'h012, '0);
        check_eq("rst_open_gnt_a", obs_ga, 1);
        idle(3);

        // Lock held with no B request blocks A; dropping the lock lets A through at once
        do_reset();
        step(0, 0, '0, '0, 1, 1, 1, 11'h030, 11'h07f);
        check_eq("lk_gnt_b", obs_gb, 1);
        step(1, 0, 11'h030, '0, 0, 0, 1, '0, '0);
        check_eq("lk_blocked_a", obs_ga, 0);
        step(1, 0, 11'h030, '0, 0, 0, 0, '0, '0);
        check_eq("lk_released_a", obs_ga, 1);
        idle(3);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                 DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 15)), DW'($urandom));
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout t=%0t got=running exp=finished", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter MSB_ADDR, default 11, meaning data-memory address width.
REQ-002 SHALL have parameter MSB_DATA, default 11, meaning data-memory word width.
REQ-003 SHALL have parameter LOCK_MAX, default 16, meaning the maximum number of consecutive locked grants to port B.
REQ-004 SHALL have port CLOCK_i, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports REQ_A_i, input, 1 bit, and WE_A_i, input, 1 bit: processor request and write-enable.
REQ-007 SHALL have ports ADDR_A_i, input, MSB_ADDR bits, and WDATA_A_i, input, MSB_DATA bits: processor address and write data.
REQ-008 SHALL have ports GNT_A_o, output, 1 bit; RVALID_A_o, output, 1 bit; RDATA_A_o, output, MSB_DATA bits; HOLD_A_o, output, 1 bit (processor stall).
REQ-009 SHALL have ports REQ_B_i, WE_B_i and LOCK_B_i, inputs, 1 bit each: external/debug request, write-enable and bus lock.
REQ-010 SHALL have ports ADDR_B_i, input, MSB_ADDR bits, and WDATA_B_i, input, MSB_DATA bits.
REQ-011 SHALL have ports GNT_B_o, RVALID_B_o, outputs, 1 bit each, and RDATA_B_o, output, MSB_DATA bits.
REQ-012 SHALL have ports WRRAM_o, output, 1 bit; ADDR_dm_o, output, MSB_ADDR bits; IN_DATA_o, output, MSB_DATA bits: the RAM command.
REQ-013 SHALL have port OUT_DATA_i, input, MSB_DATA bits: RAM asynchronous read data for the address on ADDR_dm_o.

Function
REQ-014 SHALL grant at most one port per cycle; GNT_x_o is combinational in the cycle t the request is accepted, and the request is consumed at the edge ending t.
REQ-015 SHALL register the accepted command so that cycle t+1 shows ADDR_dm_o/IN_DATA_o of the granted port and WRRAM_o=WE of that port.
REQ-016 SHALL, in any cycle following a cycle with no grant, hold WRRAM_o=0 and hold ADDR_dm_o and IN_DATA_o at their previous values.
REQ-017 SHALL, for a read granted in cycle t, register OUT_DATA_i at the end of t+1 and assert RVALID_x_o=1 with RDATA_x_o valid for exactly cycle t+2; writes produce no RVALID.
REQ-018 SHALL sustain one grant per cycle (fully pipelined); back-to-back reads on either port return in grant order.
REQ-019 SHALL, when only one port requests and no lock blocks it, grant that port.
REQ-020 SHALL arbitrate round-robin when both ports request: grant the port not granted most recently (pointer LAST, updated on every grant).
REQ-021 SHALL enter state LOCKED when B is granted with LOCK_B_i=1; in LOCKED only B may be granted, and A requests wait.
REQ-022 SHALL return from LOCKED to state OPEN when B is granted with LOCK_B_i=0, or when B has no request while LOCK_B_i=0.
REQ-023 SHALL count consecutive locked B grants; when the count reaches LOCK_MAX and REQ_A_i=1, the next grant SHALL go to A (forced release), the counter clears, and the state stays LOCKED.
REQ-024 SHALL drive HOLD_A_o = REQ_A_i AND NOT GNT_A_o, combinationally.
REQ-025 SHALL keep RDATA_x_o at the last returned value when RVALID_x_o=0.

Reset
REQ-026 SHALL, while RESET_i=0, asynchronously force: state OPEN; LAST=B, so A wins the first contention; lock counter 0; WRRAM_o=0; ADDR_dm_o=0; IN_DATA_o=0; RVALID_A_o=RVALID_B_o=0; RDATA_A_o=RDATA_B_o=0.
REQ-027 SHALL hold GNT_A_o=GNT_B_o=0 while RESET_i=0.
REQ-028 SHALL discard any in-flight read when reset is asserted mid-operation, so no RVALID follows reset release.
REQ-029 SHALL accept requests from the first rising edge after RESET_i deasserts.

Verification
REQ-030 SHALL pass: A writes 0x155 to address 0x010 in cycle t -> GNT_A_o=1 in t; WRRAM_o=1, ADDR_dm_o=0x010, IN_DATA_o=0x155 in t+1.
REQ-031 SHALL pass: A reads 0x010 (RAM returns 0x155) -> RVALID_A_o=1 and RDATA_A_o=0x155 in t+2 only.
REQ-032 SHALL pass: A and B request continuously from reset -> grants alternate A,B,A,B; HOLD_A_o=1 on B cycles.
REQ-033 SHALL pass: B locked burst of 20 with A requesting, LOCK_MAX=16 -> 16 B grants, 1 A grant, then the remaining 4 B grants.
REQ-034 SHALL pass: B read granted, RESET_i pulsed low in t+1 -> no RVALID_B_o, WRRAM_o=0, state OPEN afterwards.
REQ-035 SHALL pass: B grant with LOCK_B_i=1 then LOCK_B_i=0 with no request -> the next A request is granted in the same cycle.
